// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial line constants and transmitter state encoding
package serial_pkg;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic LINE_IDLE       = 1'b1;
  localparam logic LINE_START      = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/transmit_fifo.sv
// rtl/transmit_fifo.sv - circular word buffer feeding the serializer
module transmit_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [FRAME_DATA_BITS-1:0]   wdata,
  input  logic                         pop,
  output logic [FRAME_DATA_BITS-1:0]   rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [FRAME_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [LW-1:0]              count;
  logic                       do_push;
  logic                       do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/transmit.sv
// rtl/transmit.sv - buffered serial transmitter: start bit, 8 data bits MSB first, stop bits
module transmit
  import serial_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FRAME_DATA_BITS-1:0]  word,
  input  logic                        word_valid,
  output logic                        word_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int PW        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam int BW        = $clog2(FRAME_DATA_BITS);
  localparam logic [PW-1:0] BIT_LAST  = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] STOP_LAST = PW'(STOP_CLKS - 1);

  tx_state_t                  state, state_n;
  logic [FRAME_DATA_BITS-1:0] shreg, shreg_n;
  logic [BW-1:0]              bit_cnt, bit_n;
  logic [PW-1:0]              pre_cnt, pre_n;
  logic                       txd_n;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [FRAME_DATA_BITS-1:0] head;

  transmit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_valid && word_ready),
    .wdata (word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign word_ready = !full && !rst;
  assign busy       = (state != IDLE) || (level != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      pre_cnt <= '0;
      txd     <= LINE_IDLE;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_n;
      pre_cnt <= pre_n;
      txd     <= txd_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    pre_n   = pre_cnt + 1'b1;
    pop     = 1'b0;
    txd_n   = LINE_IDLE;
    case (state)
      IDLE: begin
        pre_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (pre_cnt == BIT_LAST) begin
          pre_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (pre_cnt == BIT_LAST) begin
          pre_n   = '0;
          shreg_n = {shreg[FRAME_DATA_BITS-2:0], 1'b0};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == BW'(FRAME_DATA_BITS - 1)) state_n = STOP;
        end
      end
      STOP: begin
        // Final stop clock chains straight into the next frame when data is waiting.
        if (pre_cnt == STOP_LAST) begin
          pre_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            bit_n   = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Line level is registered from the upcoming state so txd is glitch-free.
    case (state_n)
      START:   txd_n = LINE_START;
      DATA:    txd_n = shreg_n[FRAME_DATA_BITS-1];
      default: txd_n = LINE_IDLE;
    endcase
  end

endmodule
